// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the OTG host-port interface bus master.
// Optional multi-beat read bursts are enabled by defining OTG_HPI_BURST_EN.
package otg_hpi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } hpi_state_e;

  // HPI register-select values placed on otg_hpi_address
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/otg_hpi_phase_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// done is high once the count has reached zero, i.e. in the last cycle of a phase.
module otg_hpi_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/otg_hpi_master.sv
// HPI bus master: turns single valid/ready requests into timed CS/R/W strobe cycles.
// Define OTG_HPI_BURST_EN to let reads repeat the strobe for req_len beats under one CS.
module otg_hpi_master
  import otg_hpi_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int LEN_W      = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] otg_hpi_address,
  output logic              otg_hpi_cs_n,
  output logic              otg_hpi_r_n,
  output logic              otg_hpi_w_n,
  output logic [DATA_W-1:0] otg_hpi_data_out,
  output logic              otg_hpi_data_oe,
  input  logic [DATA_W-1:0] otg_hpi_data_in
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  hpi_state_e        state_reg, state_next;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              accept;
  logic              more_beats;
  logic              read_capture;

  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rsp_valid_reg;

  otg_hpi_phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  assign accept       = req_valid && (state_reg == IDLE);
  assign read_capture = (state_reg == STROBE) && tmr_done && !write_reg;

`ifdef OTG_HPI_BURST_EN
  logic [LEN_W-1:0] beats_reg;
  logic             rsp_last_reg;

  assign more_beats = (beats_reg > LEN_W'(1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      beats_reg    <= '0;
      rsp_last_reg <= 1'b0;
    end else begin
      if (accept) begin
        // Writes are always single-beat; a zero length read means one beat.
        beats_reg <= (req_write || (req_len == '0)) ? LEN_W'(1) : req_len;
      end else if ((state_reg == HOLD) && tmr_done && more_beats) begin
        beats_reg <= beats_reg - 1'b1;
      end
      rsp_last_reg <= read_capture && (beats_reg == LEN_W'(1));
    end
  end

  assign rsp_last = rsp_last_reg;
`else
  logic unused_len;

  assign unused_len = ^req_len;
  assign more_beats = 1'b0;
  assign rsp_last   = rsp_valid_reg;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = SETUP;
          tmr_load   = 1'b1;
          tmr_val    = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_next = STROBE;
          tmr_load   = 1'b1;
          tmr_val    = STROBE_LOAD;
        end
      end
      STROBE: begin
        if (tmr_done) begin
          state_next = HOLD;
          tmr_load   = 1'b1;
          tmr_val    = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          // Further burst beats skip SETUP: CS and address stay put.
          if (more_beats) begin
            state_next = STROBE;
            tmr_load   = 1'b1;
            tmr_val    = STROBE_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      addr_reg      <= '0;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg  <= req_addr;
        write_reg <= req_write;
        wdata_reg <= req_wdata;
      end
      if (read_capture) begin
        rdata_reg <= otg_hpi_data_in;
      end
      rsp_valid_reg <= read_capture;
    end
  end

  // Pin strobes decode straight from the state register so a reset clears them at once.
  always_comb begin
    otg_hpi_cs_n    = (state_reg == IDLE);
    otg_hpi_r_n     = !((state_reg == STROBE) && !write_reg);
    otg_hpi_w_n     = !((state_reg == STROBE) && write_reg);
    otg_hpi_data_oe = write_reg && (state_reg != IDLE);
  end

  assign otg_hpi_address  = addr_reg;
  assign otg_hpi_data_out = wdata_reg;
  assign rsp_valid        = rsp_valid_reg;
  assign rsp_rdata        = rdata_reg;
  assign req_ready        = (state_reg == IDLE);
  assign busy             = !req_ready;

endmodule

// File: tb/tb_otg_hpi_master.sv
// Directed bench for otg_hpi_master: per-cycle pin and response checks for reads,
// writes, bursts (when OTG_HPI_BURST_EN is defined), mid-transfer reset and back-to-back writes.
module tb_otg_hpi_master;

  localparam int S = 2;
  localparam int T = 3;
  localparam int H = 1;
  localparam int P = T + H;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_last;
  logic        busy;
  logic [1:0]  hpi_address;
  logic        hpi_cs_n;
  logic        hpi_r_n;
  logic        hpi_w_n;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] hpi_data_in;

  int n_total = 0;
  int n_bad   = 0;

  otg_hpi_master #(
    .DATA_W    (16),
    .ADDR_W    (2),
    .SETUP_CYC (S),
    .STROBE_CYC(T),
    .HOLD_CYC  (H),
    .LEN_W     (8)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_len         (req_len),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_last        (rsp_last),
    .busy            (busy),
    .otg_hpi_address (hpi_address),
    .otg_hpi_cs_n    (hpi_cs_n),
    .otg_hpi_r_n     (hpi_r_n),
    .otg_hpi_w_n     (hpi_w_n),
    .otg_hpi_data_out(hpi_data_out),
    .otg_hpi_data_oe (hpi_data_oe),
    .otg_hpi_data_in (hpi_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request; samples cycles 1..end on the falling edge and checks every pin.
  task automatic run_req(input string name, input bit wr, input logic [1:0] addr,
                         input logic [15:0] wdata, input logic [7:0] len,
                         input logic [15:0] pad, input bit step);
    int n, last_c, pos, k;
    bit in_cs, strobe, rsp;
    string tg;
    int rsp_cnt;
    rsp_cnt = 0;
    check({name, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wdata;
    req_len     = len;
    hpi_data_in = pad;
    @(posedge clk);
    #1 req_valid = 1'b0;
`ifdef OTG_HPI_BURST_EN
    n = wr ? 1 : ((len == 8'd0) ? 1 : int'(len));
`else
    n = 1;
`endif
    last_c = S + n * P + 1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      in_cs  = (c <= S + n * P);
      pos    = (c > S) ? (c - S - 1) % P : -1;
      k      = (c > S) ? (c - S - 1) / P : 0;
      strobe = (c > S) && in_cs && (pos < T);
      rsp    = !wr && (c > S) && in_cs && (pos == T);
      if (step) hpi_data_in = 16'(k + 1);
      tg = $sformatf("%s c%0d", name, c);
      check({tg, " cs_n"}, 32'(hpi_cs_n), 32'(!in_cs));
      check({tg, " r_n"}, 32'(hpi_r_n), 32'(!(strobe && !wr)));
      check({tg, " w_n"}, 32'(hpi_w_n), 32'(!(strobe && wr)));
      check({tg, " oe"}, 32'(hpi_data_oe), 32'(wr && in_cs));
      check({tg, " rsp_valid"}, 32'(rsp_valid), 32'(rsp));
      check({tg, " ready"}, 32'(req_ready), 32'(!in_cs));
      check({tg, " busy"}, 32'(busy), 32'(in_cs));
      if (in_cs) check({tg, " addr"}, 32'(hpi_address), 32'(addr));
      if (wr && in_cs) check({tg, " data_out"}, 32'(hpi_data_out), 32'(wdata));
      if (rsp) begin
        rsp_cnt++;
        check({tg, " rdata"}, 32'(rsp_rdata), step ? 32'(k + 1) : 32'(pad));
        check({tg, " last"}, 32'(rsp_last), 32'(k == n - 1));
      end
    end
    $display("txn %s: wr=%0d addr=%0d len=%0d beats=%0d responses=%0d", name, wr, addr, len,
             n, rsp_cnt);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 2'd0;
    req_wdata   = 16'd0;
    req_len     = 8'd0;
    hpi_data_in = 16'd0;
    repeat (3) @(negedge clk);

    check("rst cs_n", 32'(hpi_cs_n), 32'd1);
    check("rst r_n", 32'(hpi_r_n), 32'd1);
    check("rst w_n", 32'(hpi_w_n), 32'd1);
    check("rst address", 32'(hpi_address), 32'd0);
    check("rst data_out", 32'(hpi_data_out), 32'd0);
    check("rst rdata", 32'(rsp_rdata), 32'd0);
    check("rst oe", 32'(hpi_data_oe), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_last", 32'(rsp_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(req_ready), 32'd1);
    $display("txn reset: state checked");
    rst_n = 1'b1;
    @(negedge clk);

    run_req("rd_a3", 1'b0, 2'd3, 16'h0000, 8'd1, 16'hBEEF, 1'b0);
    run_req("wr_a2", 1'b1, 2'd2, 16'h1234, 8'd1, 16'h0000, 1'b0);
    run_req("rd_len4", 1'b0, 2'd0, 16'h0000, 8'd4, 16'h0000, 1'b1);
    run_req("rd_len0", 1'b0, 2'd1, 16'h0000, 8'd0, 16'h5A5A, 1'b0);
    run_req("wr_len3", 1'b1, 2'd0, 16'hC3C3, 8'd3, 16'h0000, 1'b0);

    // Reset pulse in the middle of a read strobe
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = 2'd3;
    req_len     = 8'd1;
    hpi_data_in = 16'h7777;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mrst pre r_n", 32'(hpi_r_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mrst cs_n", 32'(hpi_cs_n), 32'd1);
    check("mrst r_n", 32'(hpi_r_n), 32'd1);
    check("mrst rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("mrst post%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
      check($sformatf("mrst post%0d cs_n", c), 32'(hpi_cs_n), 32'd1);
      check($sformatf("mrst post%0d ready", c), 32'(req_ready), 32'd1);
    end
    $display("txn mid_reset: read aborted at cycle 4");

    // Back-to-back writes with req_valid held high
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd2;
    req_wdata = 16'hAAAA;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) req_wdata = 16'h5555;
      check($sformatf("b2b c%0d ready", c), 32'(req_ready), 32'(c == 7 || c == 14));
      check($sformatf("b2b c%0d w_n", c), 32'(hpi_w_n),
            32'(!((c >= 3 && c <= 5) || (c >= 10 && c <= 12))));
      check($sformatf("b2b c%0d strobe_outside_cs", c),
            32'(hpi_cs_n && (!hpi_r_n || !hpi_w_n)), 32'd0);
      if (c <= 6) check($sformatf("b2b c%0d data_out", c), 32'(hpi_data_out), 32'hAAAA);
      if (c >= 8 && c <= 13)
        check($sformatf("b2b c%0d data_out", c), 32'(hpi_data_out), 32'h5555);
      if (c == 14) req_valid = 1'b0;
    end
    $display("txn back_to_back: two writes, second accepted at cycle 7");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
